spike_rate_decoder: RTL and testbench

Consumes the 1-bit spike train produced by a neuron and turns it back into numbers. It runs two measurements in parallel:
- Rate: spikes counted over a programmable window, scaled to the same 6-bit range as the neuron's input current.
- Inter-spike interval (ISI): cycles between consecutive spikes.
The rate result goes out through a valid/ready holding register. The ISI result goes out as a one-cycle pulse. The block sits downstream of one neuron, on the same clock.

---
 rtl/spike_rate_decoder.sv | 133 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed spike-rate measurement behind a valid/ready
// holding register, plus an inter-spike-interval tracker emitting one-cycle pulses.
module spike_rate_decoder #(
    parameter int RATE_W = 6,
    parameter int ISI_W  = 8,
    parameter int WIN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spike,
    input  logic              enable,
    input  logic [WIN_W-1:0]  window_len,
    input  logic              out_ready,
    output logic [RATE_W-1:0] out_rate,
    output logic              out_valid,
    output logic              out_sat,
    output logic              overrun,
    output logic [ISI_W-1:0]  isi,
    output logic              isi_valid
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [WIN_W:0]    IDX_ONE  = 1;
    localparam logic [RATE_W-1:0] RATE_MAX = '1;
    localparam logic [ISI_W-1:0]  ISI_MAX  = '1;
    localparam logic [ISI_W-1:0]  ISI_ONE  = 1;

    state_t             state, state_next;
    logic [WIN_W:0]     win_len, idx, win_len_in;
    logic [RATE_W-1:0]  cnt, sum_sat;
    logic [RATE_W:0]    sum;
    logic               cnt_ovf;
    logic               start, sample, last;
    logic [ISI_W-1:0]   gap, gap_inc;
    logic               have_prior;

    // A zero window length stands for the full 2^WIN_W cycles.
    assign win_len_in = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};

    assign sum     = {1'b0, cnt} + {{RATE_W{1'b0}}, spike};
    assign sum_sat = sum[RATE_W] ? RATE_MAX : sum[RATE_W-1:0];
    assign gap_inc = (gap == ISI_MAX) ? ISI_MAX : gap + ISI_ONE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        sample     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = COUNT;
                    start      = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    sample = 1'b1;
                    last   = (idx == win_len - IDX_ONE);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt_ovf remembers that cnt pinned at max earlier in the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_len <= '0;
            idx     <= '0;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
        end else if (start || last) begin
            win_len <= win_len_in;
            idx     <= '0;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
        end else if (sample) begin
            idx     <= idx + IDX_ONE;
            cnt     <= sum_sat;
            cnt_ovf <= cnt_ovf | sum[RATE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_rate  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (last) begin
            out_rate  <= sum_sat;
            out_sat   <= cnt_ovf | sum[RATE_W];
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap        <= '0;
            have_prior <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (!enable) begin
                gap        <= '0;
                have_prior <= 1'b0;
            end else if (spike) begin
                if (have_prior) begin
                    isi       <= gap_inc;
                    isi_valid <= 1'b1;
                end
                gap        <= '0;
                have_prior <= 1'b1;
            end else begin
                gap <= gap_inc;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and directed bench for spike_rate_decoder; a reference model fills
// expectation queues and a negedge monitor consumes them as the DUT presents results.
module tb_spike_rate_decoder;

    localparam int RATE_W = 6;
    localparam int ISI_W  = 8;
    localparam int WIN_W  = 8;

    logic              clk = 1'b0;
    logic              reset, spike, enable, out_ready;
    logic [WIN_W-1:0]  window_len;
    logic [RATE_W-1:0] out_rate;
    logic              out_valid, out_sat, overrun;
    logic [ISI_W-1:0]  isi;
    logic              isi_valid;

    spike_rate_decoder #(.RATE_W(RATE_W), .ISI_W(ISI_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .reset(reset), .spike(spike), .enable(enable),
        .window_len(window_len), .out_ready(out_ready),
        .out_rate(out_rate), .out_valid(out_valid), .out_sat(out_sat),
        .overrun(overrun), .isi(isi), .isi_valid(isi_valid)
    );

    always #5 clk = ~clk;

    typedef struct {int rate; int sat;} res_t;
    res_t rate_q[$];
    int   isi_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, plain integers with no width limits.
    bit m_live = 0, m_rst = 0, m_counting = 0, m_pend = 0, m_ovr = 0;
    bit m_pulse = 0, m_have = 0;
    int m_n = 0, m_s = 0, m_len = 0, m_t = 0, m_last = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int eff_len(input logic [WIN_W-1:0] wl);
        return (wl == 0) ? (1 << WIN_W) : int'(wl);
    endfunction

    // Model: evaluates the inputs seen at each rising edge.
    initial begin
        forever begin
            bit   done;
            res_t nr;
            @(posedge clk);
            m_t++;
            done = 0;
            if (reset) begin
                m_live = 1; m_rst = 1; m_counting = 0; m_pend = 0; m_ovr = 0;
                m_pulse = 0; m_have = 0; m_n = 0; m_s = 0;
                rate_q.delete();
                isi_q.delete();
            end else begin
                m_rst = 0;
                if (!m_counting) begin
                    if (enable) begin
                        m_counting = 1; m_len = eff_len(window_len); m_n = 0; m_s = 0;
                    end
                end else if (!enable) begin
                    m_counting = 0;
                end else begin
                    m_s += int'(spike);
                    m_n++;
                    if (m_n == m_len) begin
                        done    = 1;
                        nr.rate = (m_s > 63) ? 63 : m_s;
                        nr.sat  = (m_s > 63) ? 1 : 0;
                        m_len = eff_len(window_len); m_n = 0; m_s = 0;
                    end
                end
                if (done) begin
                    if (m_pend && !out_ready) begin
                        m_ovr = 1;
                        if (rate_q.size() > 0) void'(rate_q.pop_back());
                    end
                    rate_q.push_back(nr);
                    m_pend = 1;
                end else if (m_pend && out_ready) begin
                    m_pend = 0;
                end
                m_pulse = 0;
                if (!enable) begin
                    m_have = 0;
                end else if (spike) begin
                    if (m_have) begin
                        isi_q.push_back((m_t - m_last > 255) ? 255 : m_t - m_last);
                        m_pulse = 1;
                    end
                    m_last = m_t;
                    m_have = 1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle.
    initial begin
        forever begin
            res_t r;
            int   e;
            @(negedge clk);
            if (m_live) begin
                chk("out_valid", out_valid, m_pend);
                chk("overrun", overrun, m_ovr);
                chk("isi_valid", isi_valid, m_pulse);
                if (m_rst) begin
                    chk("rst_out_rate", out_rate, 0);
                    chk("rst_out_sat", out_sat, 0);
                    chk("rst_isi", isi, 0);
                end
                if (out_valid && out_ready) begin
                    if (rate_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rate_unexpected: got rate %0d with no result expected at %0t", out_rate, $time);
                    end else begin
                        r = rate_q.pop_front();
                        chk("out_rate", out_rate, r.rate);
                        chk("out_sat", out_sat, r.sat);
                    end
                end
                if (isi_valid) begin
                    if (isi_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL isi_unexpected: got isi %0d with no interval expected at %0t", isi, $time);
                    end else begin
                        e = isi_q.pop_front();
                        chk("isi", isi, e);
                    end
                end
            end
        end
    end

    initial begin
        int dens;
        reset = 1; spike = 1; enable = 1; out_ready = 0; window_len = 10;
        tick(2);
        reset = 0;

        // Basic rate: alternating spikes, 10-cycle windows back to back.
        out_ready = 1; spike = 0;
        tick(1);
        for (int i = 0; i < 30; i++) begin
            spike = (i % 2 == 0);
            tick(1);
        end

        // Saturating window, then a 256-cycle window of silence.
        enable = 0; tick(1);
        window_len = 100; spike = 1; enable = 1;
        tick(103);
        enable = 0; tick(1);
        window_len = 0; spike = 0; enable = 1;
        tick(259);
        enable = 0; tick(2);

        // Overrun: three unconsumed windows holding 1, 2, 3 spikes.
        window_len = 4; out_ready = 0; enable = 1; spike = 0;
        tick(1);
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                spike = (i < w);
                tick(1);
            end
        end
        spike = 0; out_ready = 1;
        tick(6);
        enable = 0; tick(2);

        // ISI: 7, 1, 1, then a saturated 400-cycle gap.
        enable = 1; window_len = 20;
        for (int c = 0; c < 420; c++) begin
            spike = (c == 3 || c == 10 || c == 11 || c == 12 || c == 412);
            tick(1);
        end
        enable = 0; spike = 0; tick(2);

        // Abort at sample 5, then a fresh window; then reset with a result pending.
        window_len = 10; enable = 1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            spike = 1; tick(1);
        end
        enable = 0; tick(2);
        enable = 1;
        for (int i = 0; i < 14; i++) begin
            spike = (i % 3 == 1); tick(1);
        end
        out_ready = 0;
        tick(10);
        reset = 1; tick(1);
        reset = 0; out_ready = 1; tick(3);

        // Randomized traffic.
        dens = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(2, 90);
            spike     = ($urandom_range(0, 99) < dens);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) window_len = 8'($urandom_range(0, 15));
            reset = ($urandom_range(0, 999) == 0);
            tick(1);
        end

        reset = 0; enable = 0; spike = 0; out_ready = 1;
        tick(4);
        chk("rate_queue_drained", rate_q.size(), 0);
        chk("isi_queue_drained", isi_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
